register_file_scoreboard: RTL and testbench
===========================================

REGISTER_FILE_SCOREBOARD -- requirements
Module: register_file_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each register.
REQ-002 SHALL have parameter DEPTH, default REGISTER_DEPTH (32), number of architectural registers; address width $clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port registerport_read_1, MemoryInterface.read_in, enable/address/data, decode-stage read port 1.
REQ-006 SHALL have port registerport_read_2, MemoryInterface.read_in, enable/address/data, decode-stage read port 2.
REQ-007 SHALL have port registerport_write, MemoryInterface.write_in, enable/address/data, writeback-stage write port.
REQ-008 SHALL have port reserve_enable, input, 1, decode issued an instruction writing rd.
REQ-009 SHALL have port reserve_address, input, $clog2(DEPTH), rd of that instruction.
REQ-010 SHALL have port flush, input, 1, pipeline flush; drops all outstanding reservations.
REQ-011 SHALL have ports read_1_busy and read_2_busy, output, 1 each, the addressed register still awaits a write.

Function
REQ-012 Storage: DEPTH x WIDTH flops; register 0 reads as 0 always; writes to address 0 are ignored.
REQ-013 Read: data is combinational from address in the same cycle (zero added latency); data is 0 when enable=0.
REQ-014 Write: when registerport_write.enable=1 and address!=0, data is stored at the next rising edge.
REQ-015 Bypass: a read in the same cycle as a write to the same nonzero address returns the write data, not the stored value.
REQ-016 Scoreboard: each register has a 2-bit pending counter; register 0 counter is held at 0.
REQ-017 Reserve only (reserve_enable=1, address!=0): the counter increments; it saturates at 3.
REQ-018 Write only: the counter for the write address decrements; it holds at 0 on underflow (write to an unreserved register is legal).
REQ-019 Reserve and write to the same address in the same cycle: the counter is unchanged.
REQ-020 Reserve and write to different addresses: each counter updates independently in the same cycle.
REQ-021 Flush: all counters go to 0 at the next edge; it overrides any same-cycle reserve and write-decrement. The same-cycle write data is still stored.
REQ-022 Busy: read_N_busy=1 iff read port N enable=1 and its counter!=0. Exception: the counter is 1 and a same-cycle write hits that address, so the bypass supplies the data and busy=0.
REQ-023 Busy SHALL never depend on reserve_enable in the same cycle; a reservation takes effect from the next cycle.
REQ-024 Both read ports SHALL be fully independent; the same address on both ports yields identical data and busy.

Reset
REQ-025 While rst=1 at an edge, all registers clear to 0 and all counters clear to 0. Writes, reserves and flush in that cycle are ignored.
REQ-026 During and after reset, read data is 0 and busy outputs are 0 until new writes or reserves occur.
REQ-027 Reset asserted mid-operation (counters nonzero, write in flight) SHALL discard all state in one cycle.

Verification
REQ-028 Write x5=0xDEADBEEF, then read port 1 addr 5 next cycle -> data 0xDEADBEEF, busy 0.
REQ-029 Write x0=0x12345678, read addr 0 on both ports -> data 0x00000000. Reserve x0 -> busy stays 0.
REQ-030 Same-cycle write x7=0xA5A5A5A5 and read port 2 addr 7 (old value 0) -> data 0xA5A5A5A5. With counter=1 -> busy 0.
REQ-031 Reserve x3 twice on consecutive cycles, then one write to x3 -> busy still 1. A second write -> busy 0. Four reserves -> counter saturates at 3, and three writes clear it.
REQ-032 Reserve x9 and write x9 in the same cycle with counter=1 -> counter stays 1, busy 1 on the following read.
REQ-033 Reserve x4 and x6, assert flush with a same-cycle reserve of x8 -> all busy 0 next cycle. Then assert rst -> all reads return 0.

Source files
------------

// File: rtl/register_file_scoreboard.sv
// Register file with two combinational read ports, one write port with same-cycle bypass,
// and a per-register 2-bit pending-write counter that drives the read busy flags.
module register_file_scoreboard #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 32,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             registerport_read_1_enable,
    input  logic [AW-1:0]    registerport_read_1_address,
    output logic [WIDTH-1:0] registerport_read_1_data,
    input  logic             registerport_read_2_enable,
    input  logic [AW-1:0]    registerport_read_2_address,
    output logic [WIDTH-1:0] registerport_read_2_data,
    input  logic             registerport_write_enable,
    input  logic [AW-1:0]    registerport_write_address,
    input  logic [WIDTH-1:0] registerport_write_data,
    input  logic             reserve_enable,
    input  logic [AW-1:0]    reserve_address,
    input  logic             flush,
    output logic             read_1_busy,
    output logic             read_2_busy
);

    logic [WIDTH-1:0] regs_q    [DEPTH];
    logic [1:0]       pending_q [DEPTH];
    logic [1:0]       pending_d [DEPTH];
    logic             wr_live;
    logic             rd_en     [2];
    logic [AW-1:0]    rd_addr   [2];

    assign wr_live    = registerport_write_enable && (registerport_write_address != '0);
    assign rd_en[0]   = registerport_read_1_enable;
    assign rd_en[1]   = registerport_read_2_enable;
    assign rd_addr[0] = registerport_read_1_address;
    assign rd_addr[1] = registerport_read_2_address;

    for (genvar p = 0; p < 2; p++) begin : g_read
        logic             hit;
        logic [1:0]       cnt;
        logic [WIDTH-1:0] data;
        logic             busy;

        always_comb begin
            hit  = wr_live && (registerport_write_address == rd_addr[p]);
            cnt  = pending_q[rd_addr[p]];
            data = '0;
            busy = 1'b0;
            if (!rst && rd_en[p] && (rd_addr[p] != '0)) begin
                data = hit ? registerport_write_data : regs_q[rd_addr[p]];
                // The last outstanding write landing this cycle is served by the bypass.
                busy = (cnt != 2'd0) && !(hit && (cnt == 2'd1));
            end
        end
    end

    assign registerport_read_1_data = g_read[0].data;
    assign registerport_read_2_data = g_read[1].data;
    assign read_1_busy              = g_read[0].busy;
    assign read_2_busy              = g_read[1].busy;

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pending_d[i] = '0;
        end
        for (int unsigned i = 1; i < DEPTH; i++) begin
            logic res;
            logic wr;
            res          = reserve_enable && (reserve_address == AW'(i));
            wr           = registerport_write_enable && (registerport_write_address == AW'(i));
            pending_d[i] = pending_q[i];
            if (flush) begin
                pending_d[i] = 2'd0;
            end else if (res && !wr && (pending_q[i] != 2'd3)) begin
                pending_d[i] = pending_q[i] + 2'd1;
            end else if (wr && !res && (pending_q[i] != 2'd0)) begin
                pending_d[i] = pending_q[i] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i]    <= '0;
                pending_q[i] <= 2'd0;
            end
        end else begin
            pending_q <= pending_d;
            if (wr_live) begin
                regs_q[registerport_write_address] <= registerport_write_data;
            end
        end
    end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Scoreboard bench: driver pushes expected read results from an abstract model; a monitor
// process pops and compares them against the DUT each cycle.
module tb_register_file_scoreboard;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             r1_en, r2_en, w_en, res_en, fl;
    logic [AW-1:0]    r1_a, r2_a, w_a, res_a;
    logic [WIDTH-1:0] w_d, r1_d, r2_d;
    logic             r1_busy, r2_busy;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          done = 1'b0;
    logic [31:0] mem [DEPTH];
    int          cnt [DEPTH];

    always #5 clk = ~clk;

    register_file_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .registerport_read_1_enable (r1_en),
        .registerport_read_1_address(r1_a),
        .registerport_read_1_data   (r1_d),
        .registerport_read_2_enable (r2_en),
        .registerport_read_2_address(r2_a),
        .registerport_read_2_data   (r2_d),
        .registerport_write_enable  (w_en),
        .registerport_write_address (w_a),
        .registerport_write_data    (w_d),
        .reserve_enable             (res_en),
        .reserve_address            (res_a),
        .flush                      (fl),
        .read_1_busy                (r1_busy),
        .read_2_busy                (r2_busy)
    );

    function automatic exp_t expect_read(int port, logic en, int a);
        exp_t e;
        bit   hit;
        e.port = port;
        e.data = '0;
        e.busy = 1'b0;
        hit    = w_en && (int'(w_a) == a);
        if (!rst && en && a != 0) begin
            e.data = hit ? w_d : mem[a];
            e.busy = (cnt[a] > 0) && !(hit && cnt[a] == 1);
        end
        return e;
    endfunction

    // Stimulus for one cycle: drive on negedge, predict, then advance the model at the edge.
    task automatic cycle(input logic i_rst, input logic i_r1e, input int i_r1a,
                         input logic i_r2e, input int i_r2a, input logic i_we, input int i_wa,
                         input logic [31:0] i_wd, input logic i_re, input int i_ra,
                         input logic i_fl);
        @(negedge clk);
        rst    = i_rst;
        r1_en  = i_r1e;
        r1_a   = AW'(i_r1a);
        r2_en  = i_r2e;
        r2_a   = AW'(i_r2a);
        w_en   = i_we;
        w_a    = AW'(i_wa);
        w_d    = i_wd;
        res_en = i_re;
        res_a  = AW'(i_ra);
        fl     = i_fl;
        exp_q.push_back(expect_read(1, i_r1e, i_r1a));
        exp_q.push_back(expect_read(2, i_r2e, i_r2a));
        @(posedge clk);
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] = '0;
                cnt[i] = 0;
            end
        end else begin
            if (i_we && i_wa != 0) mem[i_wa] = i_wd;
            if (i_fl) begin
                for (int i = 0; i < DEPTH; i++) cnt[i] = 0;
            end else begin
                if (i_re && i_ra != 0 && !(i_we && i_wa == i_ra)) cnt[i_ra] = (cnt[i_ra] >= 3) ? 3 : cnt[i_ra] + 1;
                if (i_we && i_wa != 0 && !(i_re && i_ra == i_wa)) cnt[i_wa] = (cnt[i_wa] <= 0) ? 0 : cnt[i_wa] - 1;
            end
        end
    endtask

    task automatic rd(input int a1, input int a2);
        cycle(1'b0, 1'b1, a1, 1'b1, a2, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, 1'b1, a, 1'b1, a, d, 1'b0, 0, 1'b0);
    endtask

    task automatic reserve(input int a);
        cycle(1'b0, 1'b1, a, 1'b1, a, 1'b0, 0, 32'h0, 1'b1, a, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        logic [31:0] got_d;
        logic        got_b;
        forever begin
            @(negedge clk);
            #3;
            while (exp_q.size() > 0) begin
                e     = exp_q.pop_front();
                got_d = (e.port == 1) ? r1_d : r2_d;
                got_b = (e.port == 1) ? r1_busy : r2_busy;
                checks++;
                if (got_d !== e.data || got_b !== e.busy) begin
                    errors++;
                    $display("FAIL read_port%0d at %0t: got data=%h busy=%b, expected data=%h busy=%b",
                             e.port, $time, got_d, got_b, e.data, e.busy);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        if (!done) begin
            errors++;
            $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "timeout");
        end
    end

    initial begin : driver
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = '0;
            cnt[i] = 0;
        end
        rst = 1'b1; r1_en = 1'b0; r2_en = 1'b0; w_en = 1'b0; res_en = 1'b0; fl = 1'b0;
        r1_a = '0; r2_a = '0; w_a = '0; res_a = '0; w_d = '0;

        // Reset with reads and a write/reserve that must be ignored.
        cycle(1'b1, 1'b1, 5, 1'b1, 3, 1'b1, 5, 32'hFFFF_FFFF, 1'b1, 3, 1'b0);
        cycle(1'b1, 1'b1, 5, 1'b1, 3, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);
        rd(5, 3);

        wr(5, 32'hDEAD_BEEF);
        rd(5, 5);
        wr(0, 32'h1234_5678);
        rd(0, 0);
        reserve(0);
        rd(0, 0);

        reserve(7);
        cycle(1'b0, 1'b0, 0, 1'b1, 7, 1'b1, 7, 32'hA5A5_A5A5, 1'b0, 0, 1'b0);
        rd(7, 7);

        reserve(3); reserve(3);
        wr(3, 32'h3333_0001); rd(3, 3);
        wr(3, 32'h3333_0002); rd(3, 3);
        reserve(3); reserve(3); reserve(3); reserve(3); rd(3, 3);
        wr(3, 32'h1); rd(3, 3);
        wr(3, 32'h2); rd(3, 3);
        wr(3, 32'h3); rd(3, 3);
        wr(3, 32'h4); rd(3, 3);

        reserve(9);
        cycle(1'b0, 1'b1, 9, 1'b0, 0, 1'b1, 9, 32'h9999_9999, 1'b1, 9, 1'b0);
        rd(9, 9);

        reserve(4); reserve(6);
        cycle(1'b0, 1'b1, 4, 1'b1, 6, 1'b1, 4, 32'h4444_4444, 1'b1, 8, 1'b1);
        rd(4, 6); rd(8, 5);
        reserve(4);
        cycle(1'b1, 1'b1, 4, 1'b1, 5, 1'b1, 4, 32'h0BAD_0BAD, 1'b1, 6, 1'b0);
        rd(4, 5); rd(9, 6);

        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 149) == 0),
                  1'($urandom), $urandom_range(0, 7),
                  1'($urandom), $urandom_range(0, 7),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, 7), $urandom,
                  ($urandom_range(0, 1) == 0), $urandom_range(0, 7),
                  ($urandom_range(0, 39) == 0));
        end

        @(negedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
